// File: rtl/fc_data_mover_multi_if.sv
`default_nettype none
// ============================================================================
// Module : fc_data_mover_multi_if
// Brief  : BRAM port bundle of the multi-lane FC data mover (node, weight,
//          bias read ports and result write port).
// Rev    : 1.0  initial release
// ============================================================================
interface fc_data_mover_multi_if #(
    parameter int AWIDTH    = 12,
    parameter int MWIDTH    = 64,
    parameter int ACC_WIDTH = 32
);
    logic [AWIDTH-1:0]    addr_n;
    logic                 ce_n;
    logic [MWIDTH-1:0]    q_n;
    logic [AWIDTH-1:0]    addr_w;
    logic                 ce_w;
    logic [MWIDTH-1:0]    q_w;
    logic [AWIDTH-1:0]    addr_b;
    logic                 ce_b;
    logic [MWIDTH-1:0]    q_b;
    logic [AWIDTH-1:0]    addr_r;
    logic                 ce_r;
    logic                 we_r;
    logic [ACC_WIDTH-1:0] d_r;

    modport master (
        output addr_n, ce_n, addr_w, ce_w, addr_b, ce_b,
        output addr_r, ce_r, we_r, d_r,
        input  q_n, q_w, q_b
    );

    modport slave (
        input  addr_n, ce_n, addr_w, ce_w, addr_b, ce_b,
        input  addr_r, ce_r, we_r, d_r,
        output q_n, q_w, q_b
    );
endinterface
`default_nettype wire

// File: rtl/fc_data_mover_multi.sv
`default_nettype none
// ============================================================================
// Module : fc_data_mover_multi
// Brief  : NUM_CORE-lane signed MAC over packed node/weight BRAM words, plus
//          bias and optional ReLU; results written back and exposed flat.
// Rev    : 1.0  initial release
// ============================================================================
module fc_data_mover_multi #(
    parameter int CNT_BIT       = 31,
    parameter int AWIDTH        = 12,
    parameter int IN_DATA_WIDTH = 8,
    parameter int NUM_CORE      = 8,
    parameter int ACC_WIDTH     = 32
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic                          i_run,
    input  wire logic [CNT_BIT-1:0]            i_num_cnt,
    input  wire logic                          i_relu,
    input  wire logic [AWIDTH-1:0]             i_res_base,
    output logic                               o_idle,
    output logic                               o_read,
    output logic                               o_write,
    output logic                               o_done,
    fc_data_mover_multi_if.master              mem,
    output logic [NUM_CORE*ACC_WIDTH-1:0]      o_result
);

    localparam int PW   = 2 * IN_DATA_WIDTH;
    localparam int WR_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam logic [WR_W-1:0]    WR_LAST = WR_W'(NUM_CORE - 1);
    localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_BIT-1:0]     r_num;
    logic                   r_relu;
    logic [AWIDTH-1:0]      r_base;
    logic [CNT_BIT-1:0]     r_rd_cnt;
    logic [WR_W-1:0]        r_wr_cnt;
    logic                   r_valid;
    logic                   r_bias_vld;
    logic                   w_start;
    logic [NUM_CORE*ACC_WIDTH-1:0] w_final;

    assign w_start = (r_state == S_IDLE) && i_run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_relu     <= 1'b0;
            r_base     <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_valid    <= 1'b0;
            r_bias_vld <= 1'b0;
            o_result   <= '0;
        end else begin
            r_state    <= w_next;
            r_valid    <= (r_state == S_READ);
            r_bias_vld <= (r_state == S_BIAS);
            if (w_start) begin
                r_num  <= i_num_cnt;
                r_relu <= i_relu;
                r_base <= i_res_base;
            end
            r_rd_cnt <= ((r_state == S_READ) && (w_next == S_READ)) ? r_rd_cnt + CNT_ONE : '0;
            r_wr_cnt <= ((r_state == S_WRITE) && (w_next == S_WRITE)) ? r_wr_cnt + 1'b1 : '0;
            // Accumulators are final after S_DRAIN, so the first write cycle captures them.
            if (w_start)
                o_result <= '0;
            else if ((r_state == S_WRITE) && (r_wr_cnt == '0))
                o_result <= w_final;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_idle      = 1'b0;
        o_read      = 1'b0;
        o_write     = 1'b0;
        o_done      = 1'b0;
        mem.ce_n    = 1'b0;
        mem.ce_w    = 1'b0;
        mem.ce_b    = 1'b0;
        mem.ce_r    = 1'b0;
        mem.we_r    = 1'b0;
        mem.addr_n  = r_rd_cnt[AWIDTH-1:0];
        mem.addr_w  = r_rd_cnt[AWIDTH-1:0];
        mem.addr_b  = '0;
        mem.addr_r  = '0;
        mem.d_r     = '0;
        case (r_state)
            S_IDLE: begin
                o_idle = 1'b1;
                if (i_run) w_next = S_BIAS;
            end
            S_BIAS: begin
                mem.ce_b = 1'b1;
                w_next   = (r_num != '0) ? S_READ : S_DRAIN;
            end
            S_READ: begin
                o_read   = 1'b1;
                mem.ce_n = 1'b1;
                mem.ce_w = 1'b1;
                if (r_rd_cnt == r_num - CNT_ONE) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: begin
                o_write    = 1'b1;
                mem.ce_r   = 1'b1;
                mem.we_r   = 1'b1;
                mem.addr_r = r_base + AWIDTH'(r_wr_cnt);
                mem.d_r    = w_final[int'(r_wr_cnt)*ACC_WIDTH +: ACC_WIDTH];
                if (r_wr_cnt == WR_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    for (genvar c = 0; c < NUM_CORE; c++) begin : g_lane
        logic signed [IN_DATA_WIDTH-1:0] w_node;
        logic signed [IN_DATA_WIDTH-1:0] w_wt;
        logic signed [IN_DATA_WIDTH-1:0] w_bias;
        logic signed [PW-1:0]            w_prod;
        logic signed [ACC_WIDTH-1:0]     r_acc;
        logic signed [ACC_WIDTH-1:0]     r_bias;
        logic        [ACC_WIDTH-1:0]     w_sum;

        assign w_node = mem.q_n[c*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        assign w_wt   = mem.q_w[c*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        assign w_bias = mem.q_b[c*IN_DATA_WIDTH +: IN_DATA_WIDTH];
        assign w_prod = w_node * w_wt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_acc  <= '0;
                r_bias <= '0;
            end else begin
                if (w_start)
                    r_acc <= '0;
                else if (r_valid)
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                if (r_bias_vld)
                    r_bias <= ACC_WIDTH'(w_bias);
            end
        end

        assign w_sum = r_acc + r_bias;
        assign w_final[c*ACC_WIDTH +: ACC_WIDTH] =
            (r_relu && w_sum[ACC_WIDTH-1]) ? '0 : w_sum;
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_data_mover_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_data_mover_multi
// Brief  : Self-checking bench running a 32-bit and a 16-bit accumulator
//          variant side by side against a cycle-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fc_data_mover_multi;

    localparam int NC = 4;
    localparam int IW = 8;
    localparam int AW = 12;
    localparam int CB = 31;
    localparam int MW = NC * IW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_run = 1'b0;
    logic          i_relu = 1'b0;
    logic [CB-1:0] i_num_cnt = '0;
    logic [AW-1:0] i_res_base = '0;

    logic idle32, read32, write32, done32;
    logic idle16, read16, write16, done16;
    logic [NC*32-1:0] res32;
    logic [NC*16-1:0] res16;

    fc_data_mover_multi_if #(.AWIDTH(AW), .MWIDTH(MW), .ACC_WIDTH(32)) m32 ();
    fc_data_mover_multi_if #(.AWIDTH(AW), .MWIDTH(MW), .ACC_WIDTH(16)) m16 ();

    fc_data_mover_multi #(.CNT_BIT(CB), .AWIDTH(AW), .IN_DATA_WIDTH(IW),
                          .NUM_CORE(NC), .ACC_WIDTH(32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_relu(i_relu), .i_res_base(i_res_base), .o_idle(idle32), .o_read(read32),
        .o_write(write32), .o_done(done32), .mem(m32), .o_result(res32));

    fc_data_mover_multi #(.CNT_BIT(CB), .AWIDTH(AW), .IN_DATA_WIDTH(IW),
                          .NUM_CORE(NC), .ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_relu(i_relu), .i_res_base(i_res_base), .o_idle(idle16), .o_read(read16),
        .o_write(write16), .o_done(done16), .mem(m16), .o_result(res16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared read-only memories with one-cycle latency
    logic [MW-1:0] node_mem [16];
    logic [MW-1:0] wt_mem   [16];
    logic [MW-1:0] bias_word;
    logic [31:0]   rmem32   [4096];
    logic [15:0]   rmem16   [4096];

    always @(posedge clk) begin
        if (m32.ce_n) m32.q_n <= node_mem[m32.addr_n[3:0]];
        if (m32.ce_w) m32.q_w <= wt_mem[m32.addr_w[3:0]];
        if (m32.ce_b) m32.q_b <= bias_word;
        if (m16.ce_n) m16.q_n <= node_mem[m16.addr_n[3:0]];
        if (m16.ce_w) m16.q_w <= wt_mem[m16.addr_w[3:0]];
        if (m16.ce_b) m16.q_b <= bias_word;
        if (m32.ce_r && m32.we_r) rmem32[m32.addr_r] <= m32.d_r;
        if (m16.ce_r && m16.we_r) rmem16[m16.addr_r] <= m16.d_r;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_active = 1'b0;
    int           m_rel = 0;
    int           m_n = 0;
    bit           m_relu = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic [31:0]  m_f32 [NC];
    logic [15:0]  m_f16 [NC];
    logic [127:0] m_ores32 = '0;
    logic [63:0]  m_ores16 = '0;

    function automatic longint lane_sum(input int c, input int n);
        longint s = 0;
        logic [MW-1:0] w;
        logic signed [IW-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            w = node_mem[i]; a = w[c*IW +: IW];
            w = wt_mem[i];   b = w[c*IW +: IW];
            s += longint'(a) * longint'(b);
        end
        w = bias_word; a = w[c*IW +: IW];
        s += longint'(a);
        return s;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_active = 1'b0;
            m_ores32 = '0;
            m_ores16 = '0;
        end else if (!m_active) begin
            if (i_run) begin
                m_active = 1'b1;
                m_rel    = 1;
                m_n      = int'(i_num_cnt);
                m_relu   = i_relu;
                m_base   = i_res_base;
                m_ores32 = '0;
                m_ores16 = '0;
                for (int c = 0; c < NC; c++) begin
                    longint s;
                    s = lane_sum(c, m_n);
                    m_f32[c] = s[31:0];
                    m_f16[c] = s[15:0];
                    if (m_relu && m_f32[c][31]) m_f32[c] = '0;
                    if (m_relu && m_f16[c][15]) m_f16[c] = '0;
                end
            end
        end else begin
            m_rel++;
            if (m_rel == m_n + 4) begin
                for (int c = 0; c < NC; c++) begin
                    m_ores32[c*32 +: 32] = m_f32[c];
                    m_ores16[c*16 +: 16] = m_f16[c];
                end
            end
            if (m_rel == m_n + NC + 4) m_active = 1'b0;
        end
    end

    task automatic cmp(input string t, input logic idle, rd, wr, dn, cen, cew, ceb,
                       input logic [AW-1:0] an, aw, ab, input logic cer, wer,
                       input logic [AW-1:0] ar, input logic [31:0] dr, input logic [127:0] ores,
                       input logic [31:0] edr, input logic [127:0] eores);
        bit e_read, e_write;
        int k;
        e_read  = m_active && m_rel >= 2 && m_rel <= m_n + 1;
        e_write = m_active && m_rel >= m_n + 3 && m_rel <= m_n + NC + 2;
        k       = m_rel - m_n - 3;
        check({t, "_idle"}, idle, !m_active);
        check({t, "_read"}, rd, e_read);
        check({t, "_write"}, wr, e_write);
        check({t, "_done"}, dn, m_active && m_rel == m_n + NC + 3);
        check({t, "_ce_nw"}, {cen, cew}, {e_read, e_read});
        check({t, "_ce_b"}, ceb, m_active && m_rel == 1);
        check({t, "_addr_nw"}, {an, aw}, e_read ? {AW'(m_rel - 2), AW'(m_rel - 2)} : '0);
        check({t, "_addr_b"}, ab, 0);
        check({t, "_ce_we_r"}, {cer, wer}, {e_write, e_write});
        check({t, "_addr_r"}, ar, e_write ? AW'(int'(m_base) + k) : '0);
        check({t, "_d_r"}, dr, e_write ? edr : '0);
        check({t, "_o_result"}, ores, eores);
    endtask

    initial forever begin
        logic [31:0] e32, e16;
        int k;
        @(negedge clk);
        k   = m_rel - m_n - 3;
        e32 = (k >= 0 && k < NC) ? m_f32[k] : '0;
        e16 = (k >= 0 && k < NC) ? {16'd0, m_f16[k]} : '0;
        cmp("d32", idle32, read32, write32, done32, m32.ce_n, m32.ce_w, m32.ce_b,
            m32.addr_n, m32.addr_w, m32.addr_b, m32.ce_r, m32.we_r, m32.addr_r,
            m32.d_r, res32, e32, m_ores32);
        cmp("d16", idle16, read16, write16, done16, m16.ce_n, m16.ce_w, m16.ce_b,
            m16.addr_n, m16.addr_w, m16.addr_b, m16.ce_r, m16.we_r, m16.addr_r,
            {16'd0, m16.d_r}, {64'd0, res16}, e16, {64'd0, m_ores16});
    end

    // ---------------- directed stimulus ----------------
    task automatic load(input logic [MW-1:0] nd, input logic [MW-1:0] wt, input logic [MW-1:0] bs);
        for (int i = 0; i < 16; i++) begin
            node_mem[i] = nd;
            wt_mem[i]   = wt;
        end
        bias_word = bs;
    endtask

    // Called #1 after a posedge; returns #1 into the first idle cycle after o_done.
    task automatic run(input int n, input bit relu, input logic [AW-1:0] base,
                       input int pulse_at, output int done_rel);
        int  c0;
        bit  seen;
        seen       = 1'b0;
        done_rel   = -1;
        i_run      = 1'b1;
        i_num_cnt  = CB'(n);
        i_relu     = relu;
        i_res_base = base;
        c0         = cyc;
        @(posedge clk); #1;
        i_run      = 1'b0;
        i_num_cnt  = '1;
        i_relu     = !relu;
        i_res_base = ~base;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            i_run = (pulse_at > 0) && (cyc - c0 == pulse_at);
            if (done32) begin
                seen     = 1'b1;
                done_rel = cyc - c0;
            end
        end
        i_run = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no o_done, expected o_done within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic lanes(input string nm, input logic [AW-1:0] base,
                         input logic [127:0] e32, input logic [63:0] e16);
        check({nm, "_ores32"}, res32, e32);
        check({nm, "_ores16"}, {64'd0, res16}, {64'd0, e16});
        for (int k = 0; k < NC; k++) begin
            check({nm, "_wr32"}, rmem32[AW'(int'(base) + k)], e32[k*32 +: 32]);
            check({nm, "_wr16"}, rmem16[AW'(int'(base) + k)], e16[k*16 +: 16]);
        end
    endtask

    initial begin
        int d;
        load('0, '0, '0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic MAC plus bias
        load(32'h02020202, 32'h03030303, 32'h01010101);
        run(1, 1'b0, 12'h010, 0, d);
        check("s1_done_cycle", d, 8);
        lanes("s1", 12'h010, {4{32'd7}}, {4{16'd7}});

        // Negative products, ReLU off then on
        load(32'hFFFFFFFF, 32'h05050505, 32'h00000000);
        run(4, 1'b0, 12'h020, 0, d);
        check("s2_done_cycle", d, 11);
        lanes("s2", 12'h020, {4{32'hFFFFFFEC}}, {4{16'hFFEC}});
        run(4, 1'b1, 12'h030, 0, d);
        lanes("s2_relu", 12'h030, '0, '0);

        // N = 0: bias only
        load('0, '0, 32'h0001807F);
        run(0, 1'b0, 12'h040, 0, d);
        check("s3_done_cycle", d, 7);
        lanes("s3", 12'h040, {32'd0, 32'd1, 32'hFFFFFF80, 32'd127},
                             {16'd0, 16'd1, 16'hFF80, 16'd127});

        // Accumulator wrap in the 16-bit variant
        load(32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00000000);
        run(3, 1'b0, 12'h050, 0, d);
        lanes("s4", 12'h050, {4{32'h0000BD03}}, {4{16'hBD03}});
        run(3, 1'b1, 12'h060, 0, d);
        lanes("s4_relu", 12'h060, {4{32'h0000BD03}}, '0);

        // i_run during S_READ ignored, then immediate restart with fresh data
        load(32'hFFFFFFFF, 32'h05050505, 32'h00000000);
        run(4, 1'b0, 12'h070, 3, d);
        check("s5_done_cycle", d, 11);
        lanes("s5a", 12'h070, {4{32'hFFFFFFEC}}, {4{16'hFFEC}});
        load(32'h01010101, 32'hFEFEFEFE, 32'h00000000);
        node_mem[0] = 32'h04030201;
        run(2, 1'b0, 12'hFFE, 0, d);
        lanes("s5b", 12'hFFE, {32'hFFFFFFF6, 32'hFFFFFFF8, 32'hFFFFFFFA, 32'hFFFFFFFC},
                              {16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC});

        // Reset in the middle of S_READ
        load(32'hFFFFFFFF, 32'h05050505, 32'h00000000);
        i_run = 1'b1; i_num_cnt = CB'(4); i_relu = 1'b0; i_res_base = 12'h080;
        @(posedge clk); #1;
        i_run = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("s6_rst_idle", {idle32, idle16}, 2'b11);
        check("s6_rst_ce_n", {m32.ce_n, m16.ce_n}, 2'b00);
        check("s6_rst_ores", {res32, res16}, '0);
        @(posedge clk);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        load(32'h02020202, 32'h03030303, 32'h01010101);
        run(1, 1'b0, 12'h090, 0, d);
        check("s6_done_cycle", d, 8);
        lanes("s6", 12'h090, {4{32'd7}}, {4{16'd7}});

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fc_data_mover_multi.md
# fc_data_mover_multi

Parametrised successor to the fixed 8-lane fully-connected data mover. It streams packed node and weight words from two read-only BRAMs and performs a signed multiply-accumulate in NUM_CORE parallel lanes. A per-lane bias word, fetched once, is added and ReLU is optionally applied. The lane results are then written back sequentially to a result BRAM and also exposed on a flattened bus, so the AXI control wrapper no longer needs per-core result ports.

## Interface
- CNT_BIT, 31: width of the element counter i_num_cnt.
- AWIDTH, 12: BRAM address width.
- IN_DATA_WIDTH, 8: signed lane operand width.
- NUM_CORE, 8: number of lanes; packed memory word width MWIDTH = NUM_CORE*IN_DATA_WIDTH.
- ACC_WIDTH, 32: signed accumulator and result width; also the result BRAM word width.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_run  in  1  start pulse, accepted only in S_IDLE.
- i_num_cnt  in  CNT_BIT  number of node/weight words N; 0 is legal.
- i_relu  in  1  enables ReLU; sampled with i_run.
- i_res_base  in  AWIDTH  first result BRAM address; sampled with i_run.
- o_idle, o_read, o_write, o_done  out  1 each  state flags.
- addr_n, ce_n  out  AWIDTH, 1  node BRAM read port.
- q_n  in  MWIDTH  node BRAM read data.
- addr_w, ce_w  out  AWIDTH, 1  weight BRAM read port.
- q_w  in  MWIDTH  weight BRAM read data.
- addr_b, ce_b  out  AWIDTH, 1  bias BRAM read port.
- q_b  in  MWIDTH  bias BRAM read data.
- addr_r, ce_r, we_r  out  AWIDTH, 1, 1  result BRAM write port.
- d_r  out  ACC_WIDTH  result BRAM write data.
- o_result  out  NUM_CORE*ACC_WIDTH  final lane results; lane c occupies bits [(c+1)*ACC_WIDTH-1 : c*ACC_WIDTH].

## Operation
- Lane c operand = bits [(c+1)*IN_DATA_WIDTH-1 : c*IN_DATA_WIDTH] of q_n, q_w and q_b (lane 0 is the LSB slice). All operands are two's complement.
- States and transitions:
  - S_IDLE -> S_BIAS on i_run.
  - S_BIAS lasts 1 cycle. It goes -> S_READ if N>0, else -> S_DRAIN.
  - S_READ lasts N cycles, then -> S_DRAIN.
  - S_DRAIN lasts 1 cycle, then -> S_WRITE.
  - S_WRITE lasts NUM_CORE cycles, then -> S_DONE.
  - S_DONE lasts 1 cycle, then -> S_IDLE.
- On i_run accepted:
  - Capture N, i_relu and i_res_base.
  - Clear all accumulators.
  - Clear the o_result register.
- S_BIAS: ce_b=1, addr_b=0. At the end of the following cycle, each lane's bias is captured, sign-extended to ACC_WIDTH.
- S_READ: ce_n=ce_w=1; addr_n=addr_w=read counter, counting 0..N-1. The read counter is 0 outside S_READ.
- r_valid = ce_n delayed 1 cycle. When r_valid=1: acc_c <= acc_c + sext(q_n_c * q_w_c). The product is the full 2*IN_DATA_WIDTH-bit signed product; the sum wraps modulo 2^ACC_WIDTH with no saturation.
- Final value per lane:
  - f_c = acc_c + bias_c, wrapping.
  - If relu is on and f_c is negative, f_c = 0.
- o_result is loaded with all f_c on the first S_WRITE cycle and holds until the next accepted i_run.
- S_WRITE cycle k (k = 0..NUM_CORE-1): ce_r=we_r=1, addr_r=i_res_base+k (wraps modulo 2^AWIDTH), d_r=f_k.
- Flags:
  - o_idle = S_IDLE.
  - o_read = S_READ.
  - o_write = S_WRITE.
  - o_done = S_DONE.
- i_run outside S_IDLE is ignored; changes on i_num_cnt, i_relu or i_res_base while busy have no effect.
- ce_n, ce_w and ce_b are never asserted outside their states. The read BRAMs are never written.

## Timing
- Reset values: all state to S_IDLE; o_idle=1; every other output 0, including all addresses, enables, d_r and o_result; accumulators and biases 0.
- Reset asserted mid-operation aborts immediately. No further BRAM access occurs, and the next i_run works normally.
- BRAM read latency is exactly 1 cycle.
- With i_run high in cycle 0:
  - S_BIAS is cycle 1.
  - S_READ is cycles 2..N+1.
  - Last accumulate happens in cycle N+2 (S_DRAIN).
  - Writes occur in cycles N+3..N+NUM_CORE+2.
  - o_done is high only in cycle N+NUM_CORE+3.
  - o_idle returns in cycle N+NUM_CORE+4.
- The earliest restart is an i_run in the first o_idle cycle.

## Test plan
- NUM_CORE=4, N=1, every lane node=2, weight=3, bias=1 -> d_r=7 at addr_r=base..base+3, o_result lanes all 7, o_done in cycle 8.
- N=4, node=0xFF (-1), weight=5, bias=0, i_relu=0 -> d_r=0xFFFFFFEC (-20). Same stimulus with i_relu=1 -> d_r=0.
- N=0, lane biases 0x7F, 0x80, 0x01, 0x00 -> results 127, -128, 1, 0. ce_n and ce_w never high; o_done in cycle 7.
- ACC_WIDTH=16, N=3, node=127, weight=127, bias=0 -> d_r=0xBD03 (wrapped). With i_relu=1 -> 0.
- i_run pulsed during S_READ is ignored. A second run issued after o_done with different data gives fresh results, proving the accumulators were cleared.
- reset_n pulsed low during S_READ -> all outputs 0 and o_idle=1 during reset. A following run of scenario 1 passes.
